// File: rtl/soc_bram_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : soc_bram_ctl_pkg
// Brief   : State encoding and big-endian byte-lane helper for soc_bram_ctl.
// Revision: 1.0 - initial release
// ============================================================================
package soc_bram_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [1:0] C_LAST_BYTE = 2'd3;

  // Byte index 0 is the most significant byte: lsb position = (3 - idx) * 8.
  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_bram_ctl_if.sv
`default_nettype none
// ============================================================================
// Module  : soc_bram_ctl_if
// Brief   : SoC-side stb/ack word request bus of soc_bram_ctl.
// Revision: 1.0 - initial release
// ============================================================================
interface soc_bram_ctl_if;

  logic        i_stb;
  logic        i_rw;
  logic [31:0] i_addr;
  logic [31:0] i_dtw;
  logic [31:0] o_dtr;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_stb, i_rw, i_addr, i_dtw,
    input  o_dtr, o_ack, o_busy
  );

  modport slave (
    input  i_stb, i_rw, i_addr, i_dtw,
    output o_dtr, o_ack, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/soc_bram_ctl.sv
`default_nettype none
// ============================================================================
// Module  : soc_bram_ctl
// Brief   : Splits 32-bit word requests into four big-endian byte accesses
//           on a byte-wide BRAM with a one-cycle registered read.
// Revision: 1.0 - initial release
// ============================================================================
module soc_bram_ctl
  import soc_bram_ctl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  soc_bram_ctl_if.slave              bus,
  output logic      [ADDR_WIDTH-1:0] bram_addr,
  output logic      [7:0]            bram_din,
  output logic                       bram_we,
  input  wire logic [7:0]            bram_dout
);

  state_t                r_state;
  state_t                w_next_state;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_rw;
  logic [31:0]           r_wdata;
  logic [31:0]           r_dtr;
  logic                  w_accept;
  logic                  w_capture;
  logic [4:0]            w_cap_lsb;
  logic                  w_unused_addr_bits;

  assign w_accept = (r_state == ST_IDLE) && bus.i_stb;

  // Read data lags the address by one cycle, so XFER cnt=k lands byte k-1
  // and DRAIN lands the final byte.
  assign w_capture = !r_rw &&
                     (((r_state == ST_XFER) && (r_cnt != 2'd0)) ||
                      (r_state == ST_DRAIN));
  assign w_cap_lsb = lane_lsb((r_state == ST_DRAIN) ? C_LAST_BYTE
                                                    : (r_cnt - 2'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_stb) w_next_state = ST_XFER;
      ST_XFER:  if (r_cnt == C_LAST_BYTE) w_next_state = r_rw ? ST_ACK : ST_DRAIN;
      ST_DRAIN: w_next_state = ST_ACK;
      ST_ACK:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 2'd0;
      r_base  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= 32'd0;
      r_dtr   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 2'd0;
        r_base  <= {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
        r_rw    <= bus.i_rw;
        r_wdata <= bus.i_dtw;
      end
      // cnt parks at 3 so DRAIN keeps presenting the last byte address.
      if ((r_state == ST_XFER) && (r_cnt != C_LAST_BYTE)) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_capture) begin
        r_dtr[w_cap_lsb +: 8] <= bram_dout;
      end
    end
  end

  assign bram_addr  = r_base | ADDR_WIDTH'(r_cnt);
  assign bram_din   = r_wdata[lane_lsb(r_cnt) +: 8];
  assign bram_we    = (r_state == ST_XFER) && r_rw;

  assign bus.o_dtr  = r_dtr;
  assign bus.o_ack  = (r_state == ST_ACK);
  assign bus.o_busy = (r_state != ST_IDLE);

  // Address bits outside the BRAM word index alias and are intentionally dropped.
  assign w_unused_addr_bits = ^{bus.i_addr[31:ADDR_WIDTH], bus.i_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_soc_bram_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_soc_bram_ctl
// Brief   : Directed self-checking bench for soc_bram_ctl with a byte BRAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_soc_bram_ctl;

  localparam int ADDR_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [7:0]            bram_din;
  logic                  bram_we;
  logic [7:0]            bram_dout;

  soc_bram_ctl_if bus ();

  soc_bram_ctl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  // Byte BRAM: registered read, read data holds during a write cycle.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    else         bram_dout      <= mem[bram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        log_we   [0:15];
  logic [7:0]  log_addr [0:15];
  logic [7:0]  log_din  [0:15];
  logic        log_busy [0:15];
  logic        log_ack  [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample(input int c);
    log_we[c]   = bram_we;
    log_addr[c] = bram_addr;
    log_din[c]  = bram_din;
    log_busy[c] = bus.o_busy;
    log_ack[c]  = bus.o_ack;
  endtask

  // Starts a request in the next cycle (cycle 0) and returns in the ack cycle.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input logic hold, output int ack_c, output int ack_abs,
                         output logic [31:0] rdata);
    ack_c   = -1;
    ack_abs = -1;
    rdata   = 32'd0;
    tick();
    bus.i_stb  = 1'b1;
    bus.i_rw   = rw;
    bus.i_addr = addr;
    bus.i_dtw  = data;
    sample(0);
    for (int c = 1; c < 16; c++) begin
      tick();
      if (!hold) bus.i_stb = 1'b0;
      if (hold && c == 2) begin
        bus.i_addr = 32'h0000_0040;
        bus.i_dtw  = 32'h1122_3344;
      end
      sample(c);
      if (bus.o_ack) begin
        ack_c   = c;
        ack_abs = cyc;
        rdata   = bus.o_dtr;
        break;
      end
    end
    if (ack_c < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_write_log(input string tag, input logic [7:0] base, input logic [31:0] data,
                                 input int ack_c);
    logic [31:0] d;
    d = data;
    check({tag, "_ack_cycle"}, ack_c, 5);
    check({tag, "_busy_c0"}, {31'd0, log_busy[0]}, 0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("%s_we_c%0d", tag, c), {31'd0, log_we[c]}, 1);
      check($sformatf("%s_addr_c%0d", tag, c), {24'd0, log_addr[c]}, {24'd0, base + 8'(c - 1)});
      check($sformatf("%s_din_c%0d", tag, c), {24'd0, log_din[c]}, {24'd0, d[31 - 8*(c-1) -: 8]});
    end
    for (int c = 1; c <= 5; c++)
      check($sformatf("%s_busy_c%0d", tag, c), {31'd0, log_busy[c]}, 1);
    check({tag, "_we_c5"}, {31'd0, log_we[5]}, 0);
  endtask

  task automatic check_read_log(input string tag, input logic [7:0] base, input logic [31:0] rdata,
                                input logic [31:0] exp, input int ack_c);
    check({tag, "_ack_cycle"}, ack_c, 6);
    check({tag, "_dtr"}, rdata, exp);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("%s_we_c%0d", tag, c), {31'd0, log_we[c]}, 0);
      check($sformatf("%s_addr_c%0d", tag, c), {24'd0, log_addr[c]},
            {24'd0, base + 8'((c > 4) ? 3 : c - 1)});
    end
  endtask

  initial begin
    int          ack_c;
    int          a0, a1, a2, a3;
    logic [31:0] rd;

    reset_n    = 1'b0;
    bus.i_stb  = 1'b0;
    bus.i_rw   = 1'b0;
    bus.i_addr = 32'd0;
    bus.i_dtw  = 32'd0;
    tick();
    tick();
    check("rst_dtr",  bus.o_dtr, 0);
    check("rst_ack",  {31'd0, bus.o_ack}, 0);
    check("rst_busy", {31'd0, bus.o_busy}, 0);
    check("rst_we",   {31'd0, bram_we}, 0);
    check("rst_addr", {24'd0, bram_addr}, 0);
    check("rst_din",  {24'd0, bram_din}, 0);
    #2 reset_n = 1'b1;

    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, ack_c, a0, rd);
    check_write_log("wr10", 8'h10, 32'hDEAD_BEEF, ack_c);

    run_txn(1'b0, 32'h12, 32'h0, 1'b0, ack_c, a0, rd);
    check_read_log("rd12", 8'h10, rd, 32'hDEAD_BEEF, ack_c);

    run_txn(1'b1, 32'hFC, 32'h0102_0304, 1'b0, ack_c, a0, rd);
    check_write_log("wrFC", 8'hFC, 32'h0102_0304, ack_c);
    run_txn(1'b0, 32'h1FD, 32'h0, 1'b0, ack_c, a0, rd);
    check_read_log("rdFC", 8'hFC, rd, 32'h0102_0304, ack_c);

    // stb held with address/data toggled mid-transaction
    run_txn(1'b1, 32'h20, 32'hCAFE_F00D, 1'b1, ack_c, a0, rd);
    check_write_log("hold1", 8'h20, 32'hCAFE_F00D, ack_c);
    run_txn(1'b1, 32'h40, 32'h1122_3344, 1'b0, ack_c, a1, rd);
    check_write_log("hold2", 8'h40, 32'h1122_3344, ack_c);
    check("hold_gap", a1 - a0, 6);
    run_txn(1'b0, 32'h20, 32'h0, 1'b0, ack_c, a0, rd);
    check("hold_rd20", rd, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h40, 32'h0, 1'b0, ack_c, a0, rd);
    check("hold_rd40", rd, 32'h1122_3344);

    // Asynchronous reset during a write while cnt=2
    tick();
    bus.i_stb  = 1'b1;
    bus.i_rw   = 1'b1;
    bus.i_addr = 32'h10;
    bus.i_dtw  = 32'hA1B2_C3D4;
    tick();
    bus.i_stb = 1'b0;
    tick();
    tick();
    check("mid_cnt2_addr", {24'd0, bram_addr}, 32'h12);
    #2 reset_n = 1'b0;
    #1;
    check("arst_dtr",  bus.o_dtr, 0);
    check("arst_ack",  {31'd0, bus.o_ack}, 0);
    check("arst_busy", {31'd0, bus.o_busy}, 0);
    check("arst_we",   {31'd0, bram_we}, 0);
    check("arst_addr", {24'd0, bram_addr}, 0);
    check("arst_din",  {24'd0, bram_din}, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("arst_hold_ack%0d", i), {31'd0, bus.o_ack}, 0);
    end
    #2 reset_n = 1'b1;
    run_txn(1'b0, 32'h10, 32'h0, 1'b0, ack_c, a0, rd);
    check_read_log("post_rst", 8'h10, rd, 32'hA1B2_BEEF, ack_c);

    // Back-to-back read, read, write, read
    run_txn(1'b0, 32'h10, 32'h0, 1'b0, ack_c, a0, rd);
    run_txn(1'b0, 32'h14, 32'h0, 1'b0, ack_c, a1, rd);
    run_txn(1'b1, 32'h30, 32'h7766_5544, 1'b0, ack_c, a2, rd);
    run_txn(1'b0, 32'h31, 32'h0, 1'b0, ack_c, a3, rd);
    check("b2b_gap_rd", a1 - a0, 7);
    check("b2b_gap_wr", a2 - a1, 6);
    check("b2b_gap_rd2", a3 - a2, 7);
    check("b2b_rdata", rd, 32'h7766_5544);

    tick();
    check("final_idle_busy", {31'd0, bus.o_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_bram_ctl.md
Name: soc_bram_ctl

Overview:
Requester-side controller for a byte-wide soc_bram instance (8-bit data, 1-cycle registered read, no read data during a write cycle).
- Accepts 32-bit word read/write requests from the SoC bus using a stb/ack handshake.
- Sequences four byte accesses into the BRAM: big-endian, byte 0 = bits 31:24.
- Assembles read bytes into o_dtr and pulses o_ack once per completed transaction.

Parameters:
ADDR_WIDTH, 8, BRAM byte-address width; must be >= 2; matches the BRAM addr_width.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_stb  input  1  request strobe; sampled only in IDLE
i_rw  input  1  1 = write, 0 = read; latched with i_stb
i_addr  input  32  byte address; bits [1:0] ignored, bits above ADDR_WIDTH-1 ignored (aliasing)
i_dtw  input  32  write data; latched with i_stb
o_dtr  output  32  read data; valid when o_ack=1 on a read, held until next read completes
o_ack  output  1  one-cycle completion pulse
o_busy  output  1  high whenever state != IDLE
bram_addr  output  ADDR_WIDTH  BRAM byte address
bram_din  output  8  BRAM write data
bram_we  output  1  BRAM write enable
bram_dout  input  8  BRAM registered read data

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): state=IDLE, cnt=0; o_dtr, o_ack, bram_we, bram_din, bram_addr, and all latches = 0.
- Latches: base = {i_addr[ADDR_WIDTH-1:2], 2'b00}, rw, wdata. Captured on the clk edge where state=IDLE and i_stb=1.
- States: IDLE, XFER, DRAIN, ACK. 2-bit byte counter cnt.
- IDLE: bram_we=0. i_stb=1 -> XFER, cnt=0. i_stb=0 -> stay.
- XFER (4 cycles, cnt 0..3):
  - bram_addr = base | cnt.
  - Write: bram_we=1, bram_din = wdata byte cnt (cnt 0 -> [31:24], cnt 3 -> [7:0]).
  - Read: bram_we=0. On the edge ending a cycle with cnt=k (k>=1), capture bram_dout into o_dtr byte k-1.
  - cnt=3: write -> ACK; read -> DRAIN.
- DRAIN (read only, 1 cycle): bram_we=0, bram_addr holds base|3. Capture bram_dout into o_dtr[7:0]. -> ACK.
- ACK (1 cycle): o_ack=1, bram_we=0. -> IDLE unconditionally.
- Latency, counting the stb-accept cycle as cycle 0:
  - Write: o_ack in cycle 5.
  - Read: o_ack in cycle 6.
  - Back-to-back throughput: one write per 6 cycles, one read per 7.
- o_dtr bytes are updated in place during a read. Consumers sample o_dtr only on o_ack.
- o_ack, bram_we and o_busy are registered/state-decoded outputs; no combinational path from i_stb.
- i_stb outside IDLE: ignored; i_addr, i_rw and i_dtw changes mid-transaction have no effect.
- i_stb still high in the IDLE cycle after ACK: starts a new transaction. Requesters must drop stb on seeing o_ack.
- Address boundaries:
  - No wrap: base is word-aligned, so base|3 never exceeds 2^ADDR_WIDTH-1.
  - Top word = base 2^ADDR_WIDTH-4.
- bram_addr/bram_din in IDLE/ACK: don't-care; the bench checks them only when bram_we=1 or a read capture is due.
- Reset mid-transaction: immediate return to IDLE, no ack. Bytes already written remain in the BRAM (no rollback). o_dtr cleared.

Decomposition:
- Shared include soc_defs.vh: state encodings (IDLE=2'd0, XFER=2'd1, DRAIN=2'd2, ACK=2'd3) and the byte-lane select constant for big-endian ordering.
- No sub-module: single FSM plus counter and datapath, roughly 150 lines.
- Top-level SoC pairs soc_bram_ctl with soc_bram(addr_width=ADDR_WIDTH, data_width=8).

Test Plan:
- Write 0xDEADBEEF to i_addr 0x10 -> bram_we high 4 cycles. (bram_addr, bram_din) = (0x10,DE), (0x11,AD), (0x12,BE), (0x13,EF). o_ack in cycle 5, o_busy high cycles 1-5.
- Read i_addr 0x12 after the above -> bram_addr 0x10..0x13, bram_we=0. o_ack in cycle 6 with o_dtr=0xDEADBEEF.
- Top word: write 0x01020304 to i_addr 0xFC, read back from i_addr 0x1FD (aliases to 0xFD, base 0xFC) -> o_dtr=0x01020304, addresses 0xFC..0xFF only.
- i_stb held high through a write and i_addr/i_dtw toggled mid-transaction -> original transaction unaffected. Second transaction starts in the IDLE cycle after ACK.
- reset_n pulsed low during a write at cnt=2 (mid-cycle, asynchronous) -> all outputs 0 immediately, no o_ack. Bytes 0x10-0x11 updated, 0x12-0x13 unchanged. Next request runs normally.
- Back-to-back read-write-read with stb re-asserted in each IDLE cycle -> acks exactly 7, 6, 7 cycles apart. Final read returns the written value.
